traffic_phase_timer: RTL and testbench

- Dwell-time controller that sequences the traffic light FSM.
- Counts timebase ticks in the current phase and enforces minimum green, maximum green under congestion, yellow duration and an all-red clearance interval.
- Issues a one-cycle advance enable (adv_en) that the FSM uses as its state-register enable.
- Sits between the sensor/timebase logic and the FSM, and monitors the FSM's 4-bit phase code.

---
 rtl/traffic_phase_timer_if.sv | 25 ++
 rtl/traffic_phase_timer.sv | 141 ++++++++++++++
 tb/tb_traffic_phase_timer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/traffic_phase_timer_if.sv
// Bus between the phase timer and its surroundings: timebase/sensor inputs
// toward the timer, advance/status outputs back to the light FSM and monitors.
interface traffic_phase_timer_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic [3:0]       phase;
  logic             cong;
  logic             emerg_req;
  logic             adv_en;
  logic             all_red;
  logic             max_hit;
  logic [CNT_W-1:0] dwell_cnt;
  logic             phase_err;

  modport master (
    output tick, phase, cong, emerg_req,
    input  adv_en, all_red, max_hit, dwell_cnt, phase_err
  );

  modport slave (
    input  tick, phase, cong, emerg_req,
    output adv_en, all_red, max_hit, dwell_cnt, phase_err
  );
endinterface

// File: rtl/traffic_phase_timer.sv
// Dwell-time controller for the traffic light FSM. Counts ticks in the
// current phase, enforces min/max green, yellow and all-red clearance, and
// emits a one-cycle advance enable used as the FSM's state-register enable.
module traffic_phase_timer #(
  parameter int CNT_W        = 8,
  parameter int MIN_GREEN    = 8,
  parameter int MAX_GREEN    = 32,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_phase_timer_if.slave bus
);

  typedef enum logic [2:0] {GREEN, YELLOW, ALLRED, WAIT, ERR} state_t;

  // Thresholds widened by one bit so a saturated count still compares sanely.
  localparam logic [CNT_W:0] C_MIN = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0] C_MAX = (CNT_W+1)'(MAX_GREEN);
  localparam logic [CNT_W:0] C_YEL = (CNT_W+1)'(YELLOW_TIME);
  localparam logic [CNT_W:0] C_CLR = (CNT_W+1)'(YELLOW_TIME + ALL_RED_TIME);
  localparam bit             HAS_AR = (ALL_RED_TIME > 0);

  state_t           r_state;
  logic [3:0]       r_phase_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_adv, r_all_red, r_max_hit, r_err;
  logic             r_wgreen;  // WAIT was entered from GREEN
  logic             r_wcnt;    // cycles spent in WAIT

  logic             w_chg;
  state_t           w_cls;
  logic [CNT_W:0]   w_n;
  logic [CNT_W-1:0] w_cnt_nxt;
  state_t           w_state_nxt;
  logic             w_adv_nxt, w_ar_nxt, w_wg_nxt, w_wc_nxt, w_max_nxt;

  // Phase class: odd 1..7 green, even 2..8 yellow, everything else invalid.
  always_comb begin
    w_cls = ERR;
    if (bus.phase >= 4'd1 && bus.phase <= 4'd8)
      w_cls = bus.phase[0] ? GREEN : YELLOW;
  end

  assign w_chg = (bus.phase != r_phase_q);
  assign w_n   = {1'b0, r_cnt} + (CNT_W+1)'(1);

  // Dwell counter: phase change clears (dropping a coincident tick), else saturating count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_chg)                     w_cnt_nxt = '0;
    else if (bus.tick && !(&r_cnt)) w_cnt_nxt = r_cnt + 1'b1;
  end

  // Next-state and next-output decisions for the dwell FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_adv_nxt   = 1'b0;
    w_ar_nxt    = r_all_red;
    w_wg_nxt    = r_wgreen;
    w_wc_nxt    = r_wcnt;
    if (w_chg) begin
      w_state_nxt = w_cls;
      w_ar_nxt    = 1'b0;
      w_wc_nxt    = 1'b0;
    end else begin
      case (r_state)
        GREEN: if (bus.tick && (bus.emerg_req || (w_n >= C_MIN && !bus.cong) || w_n >= C_MAX)) begin
          w_adv_nxt   = 1'b1;
          w_state_nxt = WAIT;
          w_wg_nxt    = 1'b1;
          w_wc_nxt    = 1'b0;
        end
        // Yellow ignores emergency: the clearance always runs to completion.
        YELLOW: if (bus.tick && w_n >= C_YEL) begin
          if (HAS_AR) begin
            w_state_nxt = ALLRED;
            w_ar_nxt    = 1'b1;
          end else begin
            w_adv_nxt   = 1'b1;
            w_state_nxt = WAIT;
            w_wg_nxt    = 1'b0;
            w_wc_nxt    = 1'b0;
          end
        end
        ALLRED: if (bus.tick && w_n >= C_CLR) begin
          w_adv_nxt   = 1'b1;
          w_ar_nxt    = 1'b0;
          w_state_nxt = WAIT;
          w_wg_nxt    = 1'b0;
          w_wc_nxt    = 1'b0;
        end
        // FSM declined to advance: fall back to the phase's class, count kept.
        WAIT: begin
          if (r_wcnt) begin
            w_state_nxt = w_cls;
            w_wc_nxt    = 1'b0;
          end else begin
            w_wc_nxt    = 1'b1;
          end
        end
        default: ;
      endcase
    end
    w_max_nxt = (w_state_nxt == GREEN || (w_state_nxt == WAIT && w_wg_nxt)) &&
                ({1'b0, w_cnt_nxt} >= C_MAX);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= GREEN;
      r_phase_q <= 4'd1;
      r_cnt     <= '0;
      r_adv     <= 1'b0;
      r_all_red <= 1'b0;
      r_max_hit <= 1'b0;
      r_err     <= 1'b0;
      r_wgreen  <= 1'b0;
      r_wcnt    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase_q <= bus.phase;
      r_cnt     <= w_cnt_nxt;
      r_adv     <= w_adv_nxt;
      r_all_red <= w_ar_nxt;
      r_max_hit <= w_max_nxt;
      r_err     <= r_err | (w_state_nxt == ERR);
      r_wgreen  <= w_wg_nxt;
      r_wcnt    <= w_wc_nxt;
    end
  end

  assign bus.adv_en    = r_adv;
  assign bus.all_red   = r_all_red;
  assign bus.max_hit   = r_max_hit;
  assign bus.dwell_cnt = r_cnt;
  assign bus.phase_err = r_err;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer; the bench plays the light FSM.
module tb_traffic_phase_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  traffic_phase_timer_if #(.CNT_W(8)) bus ();

  traffic_phase_timer #(
    .CNT_W(8), .MIN_GREEN(8), .MAX_GREEN(32), .YELLOW_TIME(3), .ALL_RED_TIME(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One clock with the given tick level; outputs are sampled 1ns after the edge.
  task automatic step(input logic t);
    bus.tick = t;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
  endtask

  initial begin
    bus.tick = 0; bus.phase = 4'd1; bus.cong = 0; bus.emerg_req = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_adv", bus.adv_en, 0);
    chk("rst_cnt", bus.dwell_cnt, 0);
    chk("rst_ar",  bus.all_red, 0);
    chk("rst_max", bus.max_hit, 0);
    chk("rst_err", bus.phase_err, 0);

    // Async reset while a pulse is up and dwell_cnt=5
    repeat (4) step(1);
    bus.emerg_req = 1;
    step(1);
    bus.emerg_req = 0;
    chk("pre_rst_adv", bus.adv_en, 1);
    chk("pre_rst_cnt", bus.dwell_cnt, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_adv", bus.adv_en, 0);
    chk("arst_cnt", bus.dwell_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0);
    chk("rel_cnt", bus.dwell_cnt, 0);
    chk("rel_adv", bus.adv_en, 0);

    // Green, no congestion, tick every 4 clocks: pulse after tick 8 only
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("g_adv%0d", k), bus.adv_en, (k == 8));
      chk($sformatf("g_cnt%0d", k), bus.dwell_cnt, k);
      if (k < 8) for (int j = 0; j < 3; j++) begin
        step(0);
        chk("g_idle", bus.adv_en, 0);
      end
    end
    step(0);
    chk("g_adv_1cyc", bus.adv_en, 0);
    bus.phase = 4'd2;
    step(0);
    chk("y_clr_cnt", bus.dwell_cnt, 0);
    for (int j = 0; j < 3; j++) begin
      step(0);
      chk("y_no2nd", bus.adv_en, 0);
    end

    // Yellow + all-red, tick every cycle, emergency ignored
    for (int k = 1; k <= 5; k++) begin
      bus.emerg_req = (k <= 2);
      step(1);
      chk($sformatf("y_adv%0d", k), bus.adv_en, (k == 5));
      chk($sformatf("y_ar%0d", k), bus.all_red, (k == 3 || k == 4));
    end
    bus.emerg_req = 0;
    step(0);
    bus.phase = 4'd3;
    bus.cong = 1;
    step(0);
    chk("c_cnt0", bus.dwell_cnt, 0);

    // Congested green runs to MAX_GREEN
    for (int k = 1; k <= 32; k++) begin
      step(1);
      chk($sformatf("c_adv%0d", k), bus.adv_en, (k == 32));
      chk($sformatf("c_max%0d", k), bus.max_hit, (k == 32));
    end
    step(0);
    chk("c_max_wait", bus.max_hit, 1);
    bus.phase = 4'd4;
    bus.cong = 0;
    step(0);
    chk("c_max_yel", bus.max_hit, 0);

    // Emergency bypasses minimum green
    bus.phase = 4'd5;
    step(0);
    step(1);
    chk("e_adv1", bus.adv_en, 0);
    step(1);
    chk("e_adv2", bus.adv_en, 0);
    bus.emerg_req = 1;
    step(0);
    chk("e_noTick", bus.adv_en, 0);
    step(1);
    bus.emerg_req = 0;
    chk("e_adv3", bus.adv_en, 1);
    chk("e_cnt3", bus.dwell_cnt, 3);
    step(0);

    // Invalid phase: sticky error, no advance
    bus.phase = 4'd12;
    step(0);
    chk("err_set", bus.phase_err, 1);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("err_adv", bus.adv_en, 0);
    end
    bus.phase = 4'd1;
    step(0);
    chk("err_sticky", bus.phase_err, 1);
    chk("err_cnt0", bus.dwell_cnt, 0);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("r_adv%0d", k), bus.adv_en, (k == 8));
    end

    // FSM stays put: return to green after WAIT, next tick re-issues
    step(0);
    chk("w_adv0", bus.adv_en, 0);
    step(0);
    chk("w_cnt_kept", bus.dwell_cnt, 8);
    step(1);
    chk("w_readv", bus.adv_en, 1);
    chk("w_cnt9", bus.dwell_cnt, 9);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
